// File: rtl/infrarojo_emisor_if.sv
// -----------------------------------------------------------------------------
// infrarojo_emisor_if : sensor-board pins and CSR result bus of the IR emitter, rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface infrarojo_emisor_if #(
   parameter int N_CH = 5
);
   logic            enable;
   logic [N_CH-1:0] iSense;
   logic [N_CH-1:0] oEmit;
   logic [N_CH-1:0] oLine;
   logic [N_CH-1:0] oAmbient;
   logic            oValid;
   logic            oBusy;

   modport master (
      output enable, iSense,
      input  oEmit, oLine, oAmbient, oValid, oBusy
   );

   modport slave (
      input  enable, iSense,
      output oEmit, oLine, oAmbient, oValid, oBusy
   );
endinterface

`default_nettype wire

// File: rtl/infrarojo_emisor.sv
// -----------------------------------------------------------------------------
// infrarojo_emisor : 5-channel IR emitter sequencer with ambient cancellation, rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module infrarojo_emisor #(
   parameter int N_CH       = 5,
   parameter int OFF_CYCLES = 1000,
   parameter int ON_CYCLES  = 1000,
   parameter int GAP_CYCLES = 100000
) (
   input  wire                  clk,
   input  wire                  rst_n,
   infrarojo_emisor_if.slave    bus
);

   localparam int MAX_A   = (OFF_CYCLES > ON_CYCLES) ? OFF_CYCLES : ON_CYCLES;
   localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [CNT_W-1:0] OFF_RELOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
   localparam logic [N_CH-1:0]  ONE_HOT0   = N_CH'(1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DARK = 3'd1,
      ST_LIT  = 3'd2,
      ST_DONE = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   state_t            state_q;
   logic [CH_W-1:0]   ch_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [N_CH-1:0]   sync1_q;
   logic [N_CH-1:0]   s_sense_q;
   logic [N_CH-1:0]   dark_q;
   logic [N_CH-1:0]   lit_q;
   logic [N_CH-1:0]   emit_q;
   logic [N_CH-1:0]   line_q;
   logic [N_CH-1:0]   amb_q;
   logic              valid_q;
   logic              busy_q;
   logic              cnt_zero_d;

   assign cnt_zero_d = (cnt_q == '0);

   // Receivers are asynchronous to clk; only the second flop is ever sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         s_sense_q <= '0;
      end else begin
         sync1_q   <= bus.iSense;
         s_sense_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         cnt_q   <= '0;
         dark_q  <= '0;
         lit_q   <= '0;
         emit_q  <= '0;
         line_q  <= '0;
         amb_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.enable) begin
                  state_q <= ST_DARK;
                  ch_q    <= '0;
                  cnt_q   <= OFF_RELOAD;
                  busy_q  <= 1'b1;
               end
            end

            ST_DARK: begin
               if (!bus.enable) begin
                  state_q <= ST_IDLE;
                  emit_q  <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_zero_d) begin
                  dark_q[ch_q] <= s_sense_q[ch_q];
                  cnt_q        <= ON_RELOAD;
                  emit_q       <= ONE_HOT0 << ch_q;
                  state_q      <= ST_LIT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            // Emitter is switched off on the same edge that takes the lit sample.
            ST_LIT: begin
               if (!bus.enable) begin
                  state_q <= ST_IDLE;
                  emit_q  <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_zero_d) begin
                  lit_q[ch_q] <= s_sense_q[ch_q];
                  emit_q      <= '0;
                  if (ch_q == LAST_CH) begin
                     state_q <= ST_DONE;
                  end else begin
                     ch_q    <= ch_q + 1'b1;
                     cnt_q   <= OFF_RELOAD;
                     state_q <= ST_DARK;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            ST_DONE: begin
               line_q  <= lit_q & ~dark_q;
               amb_q   <= dark_q;
               valid_q <= 1'b1;
               cnt_q   <= GAP_RELOAD;
               busy_q  <= 1'b0;
               state_q <= ST_GAP;
            end

            ST_GAP: begin
               if (cnt_zero_d) begin
                  if (bus.enable) begin
                     state_q <= ST_DARK;
                     ch_q    <= '0;
                     cnt_q   <= OFF_RELOAD;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               emit_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oEmit    = emit_q;
   assign bus.oLine    = line_q;
   assign bus.oAmbient = amb_q;
   assign bus.oValid   = valid_q;
   assign bus.oBusy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_infrarojo_emisor.sv
// -----------------------------------------------------------------------------
// tb_infrarojo_emisor : directed vector bench for infrarojo_emisor, rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_infrarojo_emisor;

   localparam int N_CH = 5;

   typedef struct packed {
      logic [N_CH-1:0] follow;
      logic [N_CH-1:0] tie;
      logic [N_CH-1:0] exp_line;
      logic [N_CH-1:0] exp_amb;
   } vec_t;

   logic            clk;
   logic            rst_n;
   logic [N_CH-1:0] follow;
   logic [N_CH-1:0] tie;
   int              errors;
   int              checks;
   vec_t            vecs [6];

   infrarojo_emisor_if #(.N_CH(N_CH)) bus ();

   infrarojo_emisor #(
      .N_CH       (N_CH),
      .OFF_CYCLES (4),
      .ON_CYCLES  (4),
      .GAP_CYCLES (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Receiver model: a followed bit sees its own emitter, a tied bit sees constant IR.
   assign bus.iSense = (bus.oEmit & follow) | tie;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (bus.oValid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: no oValid within 200 cycles, expected a pulse", name);
      end
   endtask

   task automatic wait_emit(input logic [N_CH-1:0] want, input bit any, output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if ((any && bus.oEmit != '0) || (!any && bus.oEmit == want)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_emit: oEmit=0x%0h after 200 cycles, expected 0x%0h", bus.oEmit, want);
      end
   endtask

   initial begin
      int n;
      int bad;
      logic [N_CH-1:0] exp_emit;
      logic            exp_busy;

      errors = 0;
      checks = 0;
      //               follow    tie       line      ambient
      vecs[0] = '{5'b00101, 5'b00000, 5'b00101, 5'b00000};
      vecs[1] = '{5'b00101, 5'b01000, 5'b00101, 5'b01000};
      vecs[2] = '{5'b11111, 5'b00000, 5'b11111, 5'b00000};
      vecs[3] = '{5'b00000, 5'b10001, 5'b00000, 5'b10001};
      vecs[4] = '{5'b11111, 5'b00010, 5'b11101, 5'b00010};
      vecs[5] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000};

      // Reset held for three clocks, enable low.
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      follow     = vecs[0].follow;
      tie        = vecs[0].tie;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_emit",  32'(bus.oEmit), 32'h0);
      check("reset_line",  32'(bus.oLine), 32'h0);
      check("reset_amb",   32'(bus.oAmbient), 32'h0);
      check("reset_valid", 32'(bus.oValid), 32'h0);
      check("reset_busy",  32'(bus.oBusy), 32'h0);
      repeat (10) tick();
      check("idle_hold", 32'({bus.oValid, bus.oBusy, bus.oEmit}), 32'h0);

      // One edge to leave IDLE, then 41 more to the first strobe.
      bus.enable = 1'b1;
      wait_valid("first_valid", n);
      check("first_latency", 32'(n), 32'd42);
      check("vec0_line", 32'(bus.oLine), 32'(vecs[0].exp_line));
      check("vec0_amb",  32'(bus.oAmbient), 32'(vecs[0].exp_amb));

      // Masks change in the gap, so the next scan sees only the new pattern.
      for (int i = 1; i < 6; i++) begin
         follow = vecs[i].follow;
         tie    = vecs[i].tie;
         wait_valid("vec_valid", n);
         check("scan_period", 32'(n), 32'd49);
         check("vec_line", 32'(bus.oLine), 32'(vecs[i].exp_line));
         check("vec_amb",  32'(bus.oAmbient), 32'(vecs[i].exp_amb));
      end

      // Full-scan emitter trace, starting right after a strobe.
      follow = 5'b00101;
      tie    = 5'b01000;
      for (int k = 1; k <= 49; k++) begin
         tick();
         exp_emit = '0;
         if (k >= 8 && k <= 47 && ((k - 8) % 8) >= 4)
            exp_emit = 5'b00001 << ((k - 8) / 8);
         exp_busy = (k >= 8 && k <= 48);
         check("scan_trace", 32'({bus.oValid, bus.oBusy, bus.oEmit}),
               32'({(k == 49), exp_busy, exp_emit}));
         check("emit_onehot0", 32'($onehot0(bus.oEmit)), 32'd1);
      end
      check("trace_line", 32'(bus.oLine), 32'h05);
      check("trace_amb",  32'(bus.oAmbient), 32'h08);

      // Abort during LIT of channel 2.
      wait_emit(5'b00100, 1'b0, n);
      bus.enable = 1'b0;
      tick();
      check("abort_emit", 32'(bus.oEmit), 32'h0);
      check("abort_busy", 32'(bus.oBusy), 32'h0);
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (bus.oValid || bus.oEmit != '0) bad++;
      end
      check("abort_quiet", 32'(bad), 32'd0);
      check("abort_line_kept", 32'(bus.oLine), 32'h05);
      check("abort_amb_kept",  32'(bus.oAmbient), 32'h08);

      bus.enable = 1'b1;
      wait_emit('0, 1'b1, n);
      check("restart_emit", 32'(bus.oEmit), 32'h01);
      check("restart_delay", 32'(n), 32'd5);
      wait_valid("restart_valid", n);
      check("restart_latency", 32'(n), 32'd37);
      check("restart_line", 32'(bus.oLine), 32'h05);
      check("restart_amb",  32'(bus.oAmbient), 32'h08);

      // Asynchronous reset in the middle of a lit window.
      wait_emit('0, 1'b1, n);
      #3 rst_n = 1'b0;
      #1;
      check("async_emit", 32'(bus.oEmit), 32'h0);
      check("async_line", 32'(bus.oLine), 32'h0);
      check("async_busy", 32'(bus.oBusy), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      n   = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         n++;
         if (bus.oValid) break;
         if (bus.oLine != '0) bad++;
      end
      check("post_reset_line_zero", 32'(bad), 32'd0);
      check("post_reset_latency", 32'(n), 32'd42);
      check("post_reset_line", 32'(bus.oLine), 32'h05);
      check("post_reset_amb",  32'(bus.oAmbient), 32'h08);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
